// File: rtl/fll_arb.sv
// Round-robin, packet-aware arbiter sharing one FIFO write port between RN requesters.
// A grant is held for a whole packet or until BL transfers, then one IDLE bubble re-arbitrates.
module fll_arb #(
    parameter int DW = 1,
    parameter int RN = 4,
    parameter int BL = 4,
    parameter int RO = 1,
    localparam int IW = $clog2(RN)
) (
    input  logic               ffi_clk,
    input  logic               ffi_rst,
    input  logic [RN*DW-1:0]   req_bus,
    input  logic [RN-1:0]      req_lst,
    input  logic [RN-1:0]      req_vld,
    output logic [RN-1:0]      req_rdy,
    output logic [DW-1:0]      arb_bus,
    output logic               arb_lst,
    output logic               arb_vld,
    input  logic               arb_rdy,
    output logic [RN-1:0]      arb_gnt,
    output logic [IW-1:0]      arb_idx
);

    localparam int CW  = (BL == 0) ? 1 : $clog2(BL + 1);
    localparam int BLM = (BL == 0) ? 0 : BL - 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_reg;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] idx_reg;
    logic [RN-1:0] gnt_reg;
    logic [CW-1:0] cnt_reg;

    logic [RN-1:0] above;
    logic [RN-1:0] cand;
    logic [IW-1:0] nxt_idx;
    logic [DW-1:0] masked [RN];
    logic [DW-1:0] sel_bus;
    logic          sel_vld;
    logic          sel_lst;
    logic          acc;
    logic          xfer;
    logic          rel;

    for (genvar gi = 0; gi < RN; gi++) begin : g_lane
        assign masked[gi] = req_bus[gi*DW +: DW] & {DW{gnt_reg[gi]}};
        assign above[gi]  = (IW'(gi) > ptr_reg);
    end

    // Round-robin: prefer the lowest valid index above ptr, otherwise wrap to the lowest valid.
    always_comb begin
        cand    = (|(req_vld & above)) ? (req_vld & above) : req_vld;
        nxt_idx = '0;
        for (int i = RN - 1; i >= 0; i--) begin
            if (cand[i]) nxt_idx = IW'(i);
        end
    end

    always_comb begin
        sel_bus = '0;
        for (int i = 0; i < RN; i++) begin
            sel_bus = sel_bus | masked[i];
        end
    end

    // gnt_reg is zero outside LOCK, so these are implicitly qualified by the state.
    assign sel_vld = |(req_vld & gnt_reg);
    assign sel_lst = |(req_lst & gnt_reg);
    assign xfer    = sel_vld & acc & !ffi_rst;
    assign rel     = sel_lst | ((BL != 0) && (cnt_reg == CW'(BLM)));
    assign req_rdy = gnt_reg & {RN{acc & !ffi_rst}};
    assign arb_gnt = gnt_reg;
    assign arb_idx = idx_reg;

    always_ff @(posedge ffi_clk) begin
        if (ffi_rst) begin
            state_reg <= IDLE;
            ptr_reg   <= IW'(RN - 1);
            idx_reg   <= IW'(RN - 1);
            gnt_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_vld) begin
                        state_reg <= LOCK;
                        gnt_reg   <= RN'(1) << nxt_idx;
                        idx_reg   <= nxt_idx;
                        cnt_reg   <= '0;
                    end
                end
                LOCK: begin
                    if (xfer) begin
                        if (rel) begin
                            state_reg <= IDLE;
                            ptr_reg   <= idx_reg;
                            gnt_reg   <= '0;
                        end
                        if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    if (RO == 0) begin : g_comb
        assign acc     = arb_rdy;
        assign arb_vld = sel_vld;
        assign arb_lst = sel_lst;
        assign arb_bus = sel_bus;
    end else begin : g_reg
        logic [DW-1:0] bus_reg;
        logic          lst_reg;
        logic          vld_reg;

        // Skid-free output register: accepts a new word whenever it is empty or draining.
        assign acc = !vld_reg | arb_rdy;

        always_ff @(posedge ffi_clk) begin
            if (ffi_rst) begin
                vld_reg <= 1'b0;
                lst_reg <= 1'b0;
            end else if (xfer) begin
                bus_reg <= sel_bus;
                lst_reg <= sel_lst;
                vld_reg <= 1'b1;
            end else if (arb_rdy) begin
                vld_reg <= 1'b0;
                lst_reg <= 1'b0;
            end
        end

        assign arb_vld = vld_reg;
        assign arb_lst = lst_reg;
        assign arb_bus = bus_reg;
    end

endmodule

// File: tb/tb_fll_arb.sv
// Bench for fll_arb: directed scenarios plus a randomized run against a packet/round-robin model.
// Data words carry {source[1:0], sequence[5:0]} so every output word can be traced to its origin.
module tb_fll_arb;

    localparam int DW = 8;
    localparam int RN = 4;

    logic              ffi_clk;
    logic              srst;
    logic [RN*DW-1:0]  req_bus;
    logic [RN-1:0]     req_lst;
    logic [RN-1:0]     req_vld;
    logic              arb_rdy;

    logic [RN-1:0] rdy0, gnt0, rdy1, gnt1;
    logic [DW-1:0] bus0, bus1;
    logic          lst0, vld0, lst1, vld1;
    logic [1:0]    idx0, idx1;

    // dut0: registered output, burst cap 4. dut1: pass-through, no burst cap.
    fll_arb #(.DW(DW), .RN(RN), .BL(4), .RO(1)) u_dut0 (
        .ffi_clk(ffi_clk), .ffi_rst(srst),
        .req_bus(req_bus), .req_lst(req_lst), .req_vld(req_vld), .req_rdy(rdy0),
        .arb_bus(bus0), .arb_lst(lst0), .arb_vld(vld0), .arb_rdy(arb_rdy),
        .arb_gnt(gnt0), .arb_idx(idx0)
    );

    fll_arb #(.DW(DW), .RN(RN), .BL(0), .RO(0)) u_dut1 (
        .ffi_clk(ffi_clk), .ffi_rst(srst),
        .req_bus(req_bus), .req_lst(req_lst), .req_vld(req_vld), .req_rdy(rdy1),
        .arb_bus(bus1), .arb_lst(lst1), .arb_vld(vld1), .arb_rdy(arb_rdy),
        .arb_gnt(gnt1), .arb_idx(idx1)
    );

    initial ffi_clk = 1'b0;
    always #5 ffi_clk = ~ffi_clk;

    int n_chk = 0;
    int n_fail = 0;
    int dsel = 0;
    int src_p = 100;
    int seq_r [RN];

    logic [DW:0] src_q [RN][$];
    logic [DW:0] exp_q [RN][$];

    logic [RN-1:0]    s_gnt, s_rdy, s_reqv, s_reql, s_xfer;
    logic [DW-1:0]    s_bus;
    logic             s_vld, s_lst, s_oxfer;
    logic [1:0]       s_idx;
    logic [RN*DW-1:0] s_reqb;

    function automatic int rr_pick(int last, logic [RN-1:0] v);
        for (int k = 1; k <= RN; k++) begin
            if (v[(last + k) % RN]) return (last + k) % RN;
        end
        return -1;
    endfunction

    task automatic push_pkt(int r, int len);
        logic [DW:0] w;
        logic [1:0]  rb;
        logic [5:0]  sb;
        for (int i = 0; i < len; i++) begin
            rb = 2'(r);
            sb = 6'(seq_r[r]);
            w  = {(i == len - 1), rb, sb};
            seq_r[r]++;
            src_q[r].push_back(w);
            exp_q[r].push_back(w);
        end
    endtask

    task automatic do_reset();
        srst    = 1'b1;
        req_vld = '0;
        req_lst = '0;
        req_bus = '0;
        arb_rdy = 1'b1;
        for (int r = 0; r < RN; r++) begin
            src_q[r].delete();
            exp_q[r].delete();
            seq_r[r] = 0;
        end
        repeat (2) @(posedge ffi_clk);
        #1 srst = 1'b0;
    endtask

    // One clock: sample everything at the falling edge, then update the sources after the rising edge.
    task automatic cycle();
        @(negedge ffi_clk);
        s_gnt   = (dsel == 1) ? gnt1 : gnt0;
        s_rdy   = (dsel == 1) ? rdy1 : rdy0;
        s_bus   = (dsel == 1) ? bus1 : bus0;
        s_vld   = (dsel == 1) ? vld1 : vld0;
        s_lst   = (dsel == 1) ? lst1 : lst0;
        s_idx   = (dsel == 1) ? idx1 : idx0;
        s_reqv  = req_vld;
        s_reql  = req_lst;
        s_reqb  = req_bus;
        s_xfer  = req_vld & s_rdy;
        s_oxfer = s_vld & arb_rdy;
        @(posedge ffi_clk);
        #1;
        for (int r = 0; r < RN; r++) begin
            if (s_xfer[r]) begin
                void'(src_q[r].pop_front());
                req_vld[r] = 1'b0;
                req_lst[r] = 1'b0;
            end
            if (!req_vld[r] && src_q[r].size() > 0 && $urandom_range(99) < src_p) begin
                req_vld[r] = 1'b1;
                {req_lst[r], req_bus[r*DW +: DW]} = src_q[r][0];
            end
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        do_reset();
        @(negedge ffi_clk);
        n_chk++; if (gnt0 !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt0 got %b want 0000", gnt0); end
        n_chk++; if (idx0 !== 2'd3)    begin n_fail++; $display("FAIL reset_idx0 got %0d want 3", idx0); end
        n_chk++; if (rdy0 !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy0 got %b want 0000", rdy0); end
        n_chk++; if (vld0 !== 1'b0)    begin n_fail++; $display("FAIL reset_vld0 got %b want 0", vld0); end
        n_chk++; if (lst0 !== 1'b0)    begin n_fail++; $display("FAIL reset_lst0 got %b want 0", lst0); end
        n_chk++; if (gnt1 !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt1 got %b want 0000", gnt1); end
        n_chk++; if (vld1 !== 1'b0)    begin n_fail++; $display("FAIL reset_vld1 got %b want 0", vld1); end
        n_chk++; if (idx1 !== 2'd3)    begin n_fail++; $display("FAIL reset_idx1 got %0d want 3", idx1); end
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        logic [RN-1:0] exp_g [7] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
        logic [DW-1:0] exp_w [4] = '{8'h00, 8'h40, 8'h80, 8'hC0};
        logic [RN-1:0] gq [$];
        logic [DW-1:0] wq [$];
        dsel = 0;
        do_reset();
        for (int r = 0; r < RN; r++) begin
            push_pkt(r, 1);
            push_pkt(r, 1);
        end
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (gq.size() > 0 || s_gnt != 0) gq.push_back(s_gnt);
            if (s_oxfer) wq.push_back(s_bus);
        end
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (gq.size() <= i || gq[i] !== exp_g[i]) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d] got %b want %b", i, (gq.size() > i) ? gq[i] : 4'bxxxx, exp_g[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (wq.size() <= i || wq[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL rr_word[%0d] got %h want %h", i, (wq.size() > i) ? wq[i] : 8'hxx, exp_w[i]);
            end
        end
        $display("test_round_robin done: %0d words out", wq.size());
    endtask

    task automatic test_burst_split();
        int runs [$];
        int run_cnt = 0;
        int zeros = 0;
        int started = 0;
        logic prev_on = 1'b0;
        logic [DW:0] oq [$];
        dsel = 0;
        do_reset();
        push_pkt(1, 10);
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (s_xfer[1]) run_cnt++;
            if (prev_on && s_gnt == 0) begin
                runs.push_back(run_cnt);
                run_cnt = 0;
            end
            if (s_gnt != 0) started = 1;
            if (started && s_gnt == 0 && src_q[1].size() > 0) zeros++;
            prev_on = (s_gnt != 0);
            if (s_oxfer) oq.push_back({s_lst, s_bus});
        end
        n_chk++; if (runs.size() != 3) begin n_fail++; $display("FAIL burst_nruns got %0d want 3", runs.size()); end
        n_chk++; if (runs.size() > 0 && runs[0] != 4) begin n_fail++; $display("FAIL burst_run0 got %0d want 4", runs[0]); end
        n_chk++; if (runs.size() > 1 && runs[1] != 4) begin n_fail++; $display("FAIL burst_run1 got %0d want 4", runs[1]); end
        n_chk++; if (runs.size() > 2 && runs[2] != 2) begin n_fail++; $display("FAIL burst_run2 got %0d want 2", runs[2]); end
        n_chk++; if (zeros != 2) begin n_fail++; $display("FAIL burst_bubbles got %0d want 2", zeros); end
        n_chk++; if (oq.size() != 10) begin n_fail++; $display("FAIL burst_nwords got %0d want 10", oq.size()); end
        for (int i = 0; i < oq.size() && i < 10; i++) begin
            n_chk++;
            if (oq[i] !== {(i == 9), 8'(64 + i)}) begin
                n_fail++;
                $display("FAIL burst_word[%0d] got %h want %h", i, oq[i], {(i == 9), 8'(64 + i)});
            end
        end
        $display("test_burst_split done: %0d grants", runs.size());
    endtask

    task automatic test_stall();
        logic [DW:0] oq [$];
        logic [DW-1:0] held;
        int left = 0;
        int did = 0;
        int stall_idx = 0;
        logic stalled_now = 1'b0;
        dsel = 0;
        do_reset();
        push_pkt(0, 6);
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (stalled_now) begin
                if (stall_idx == 0) held = s_bus;
                n_chk++; if (s_vld !== 1'b1) begin n_fail++; $display("FAIL stall_vld[%0d] got %b want 1", stall_idx, s_vld); end
                n_chk++; if (s_bus !== held) begin n_fail++; $display("FAIL stall_bus[%0d] got %h want %h", stall_idx, s_bus, held); end
                n_chk++; if (s_rdy !== 4'b0000) begin n_fail++; $display("FAIL stall_rdy[%0d] got %b want 0000", stall_idx, s_rdy); end
                stall_idx++;
            end
            if (s_oxfer) oq.push_back({s_lst, s_bus});
            if (oq.size() == 2 && did == 0) begin
                did  = 1;
                left = 3;
            end
            stalled_now = (left > 0);
            if (left > 0) begin
                arb_rdy = 1'b0;
                left--;
            end else begin
                arb_rdy = 1'b1;
            end
        end
        n_chk++; if (stall_idx != 3) begin n_fail++; $display("FAIL stall_cycles got %0d want 3", stall_idx); end
        n_chk++; if (oq.size() != 6) begin n_fail++; $display("FAIL stall_nwords got %0d want 6", oq.size()); end
        for (int i = 0; i < oq.size() && i < 6; i++) begin
            n_chk++;
            if (oq[i] !== {(i == 5), 8'(i)}) begin
                n_fail++;
                $display("FAIL stall_word[%0d] got %h want %h", i, oq[i], {(i == 5), 8'(i)});
            end
        end
        $display("test_stall done: %0d words out", oq.size());
    endtask

    task automatic test_ptr_resume();
        logic [RN-1:0] exp_g [3] = '{4'b0100, 4'b1000, 4'b0001};
        logic [1:0]    exp_i [3] = '{2'd2, 2'd3, 2'd0};
        logic [RN-1:0] gq [$];
        logic [1:0]    iq [$];
        logic prev_on = 1'b0;
        int pushed = 0;
        dsel = 0;
        do_reset();
        push_pkt(2, 1);
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (!prev_on && s_gnt != 0) begin
                gq.push_back(s_gnt);
                iq.push_back(s_idx);
            end
            prev_on = (s_gnt != 0);
            if (s_xfer[2] && pushed == 0) begin
                pushed = 1;
                push_pkt(0, 1);
                push_pkt(3, 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (gq.size() <= i || gq[i] !== exp_g[i] || iq[i] !== exp_i[i]) begin
                n_fail++;
                $display("FAIL ptr_grant[%0d] got %b/%0d want %b/%0d", i,
                         (gq.size() > i) ? gq[i] : 4'bxxxx, (iq.size() > i) ? iq[i] : 2'bxx, exp_g[i], exp_i[i]);
            end
        end
        $display("test_ptr_resume done: %0d grants", gq.size());
    endtask

    task automatic test_reset_mid();
        int found = 0;
        logic [RN-1:0] first_g = '0;
        dsel = 0;
        do_reset();
        push_pkt(1, 4);
        for (int c = 0; c < 20 && found == 0; c++) begin
            cycle();
            if (s_gnt != 0 && s_vld) found = 1;
        end
        n_chk++; if (found == 0) begin n_fail++; $display("FAIL rstmid_lock got none want lock with arb_vld"); end
        srst = 1'b1;
        push_pkt(0, 1);
        push_pkt(3, 1);
        cycle();
        srst = 1'b0;
        cycle();
        n_chk++; if (s_vld !== 1'b0)    begin n_fail++; $display("FAIL rstmid_vld got %b want 0", s_vld); end
        n_chk++; if (s_gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_gnt got %b want 0000", s_gnt); end
        n_chk++; if (s_rdy !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rdy got %b want 0000", s_rdy); end
        n_chk++; if (s_idx !== 2'd3)    begin n_fail++; $display("FAIL rstmid_idx got %0d want 3", s_idx); end
        for (int c = 0; c < 20 && first_g == 0; c++) begin
            cycle();
            first_g = s_gnt;
        end
        n_chk++; if (first_g !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first got %b want 0001", first_g); end
        $display("test_reset_mid done");
    endtask

    task automatic test_passthru();
        int n_x = 0;
        int first_c = -1;
        int last_c = -1;
        int rises = 0;
        logic prev_on = 1'b0;
        dsel = 1;
        do_reset();
        push_pkt(2, 8);
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (!prev_on && s_gnt != 0) rises++;
            prev_on = (s_gnt != 0);
            if (s_xfer[2]) begin
                n_x++;
                if (first_c < 0) first_c = c;
                last_c = c;
                n_chk++;
                if (!s_oxfer || {s_lst, s_bus} !== {s_reql[2], s_reqb[2*DW +: DW]}) begin
                    n_fail++;
                    $display("FAIL pass_word[%0d] got vld=%b %b/%h want 1 %b/%h", n_x - 1, s_vld, s_lst, s_bus,
                             s_reql[2], s_reqb[2*DW +: DW]);
                end
            end
        end
        n_chk++; if (n_x != 8) begin n_fail++; $display("FAIL pass_count got %0d want 8", n_x); end
        n_chk++; if (last_c - first_c != 7) begin n_fail++; $display("FAIL pass_span got %0d want 7", last_c - first_c); end
        n_chk++; if (rises != 1) begin n_fail++; $display("FAIL pass_grants got %0d want 1", rises); end
        dsel = 0;
        $display("test_passthru done: %0d transfers", n_x);
    endtask

    task automatic test_random();
        logic [RN-1:0] prev_gnt = '0;
        logic [RN-1:0] prev_vld = '0;
        logic [RN-1:0] prev_lstv = '0;
        logic [RN-1:0] prev_x = '0;
        logic [RN-1:0] eg;
        int m_last = RN - 1;
        int run = 0;
        int pick;
        int src;
        int done = 0;
        int n_out = 0;
        dsel = 0;
        do_reset();
        src_p = 60;
        for (int r = 0; r < RN; r++) begin
            for (int p = 0; p < 5; p++) push_pkt(r, $urandom_range(1, 6));
        end
        for (int c = 0; c < 3000 && done == 0; c++) begin
            cycle();
            n_chk++;
            if ((s_rdy & ~s_gnt) != 0 || $countones(s_rdy) > 1) begin
                n_fail++;
                $display("FAIL rnd_rdy cyc %0d got rdy=%b gnt=%b want subset of grant", c, s_rdy, s_gnt);
            end
            if (prev_gnt == 0) begin
                pick = rr_pick(m_last, prev_vld);
                eg = (pick < 0) ? 4'b0000 : 4'(1 << pick);
                n_chk++;
                if (s_gnt !== eg) begin
                    n_fail++;
                    $display("FAIL rnd_grant cyc %0d got %b want %b (last=%0d vld=%b)", c, s_gnt, eg, m_last, prev_vld);
                end
                if (pick >= 0) begin
                    m_last = pick;
                    run = 0;
                end
            end else begin
                if (prev_x[m_last]) run++;
                eg = (prev_x[m_last] && (prev_lstv[m_last] || run == 4)) ? 4'b0000 : prev_gnt;
                n_chk++;
                if (s_gnt !== eg) begin
                    n_fail++;
                    $display("FAIL rnd_hold cyc %0d got %b want %b (run=%0d)", c, s_gnt, eg, run);
                end
            end
            if (s_gnt != 0) begin
                n_chk++;
                if (s_idx !== 2'(m_last)) begin
                    n_fail++;
                    $display("FAIL rnd_idx cyc %0d got %0d want %0d", c, s_idx, m_last);
                end
            end
            if (s_oxfer) begin
                src = int'(s_bus[7:6]);
                n_out++;
                n_chk++;
                if (exp_q[src].size() == 0 || {s_lst, s_bus} !== exp_q[src][0]) begin
                    n_fail++;
                    $display("FAIL rnd_word cyc %0d got %b/%h want %h", c, s_lst, s_bus,
                             (exp_q[src].size() > 0) ? exp_q[src][0] : 9'hxxx);
                end
                if (exp_q[src].size() > 0) void'(exp_q[src].pop_front());
            end
            prev_gnt  = s_gnt;
            prev_vld  = s_reqv;
            prev_lstv = s_reql;
            prev_x    = s_xfer;
            arb_rdy   = ($urandom_range(99) < 75);
            done = 1;
            for (int r = 0; r < RN; r++) begin
                if (exp_q[r].size() != 0) done = 0;
            end
        end
        n_chk++;
        if (done == 0) begin
            n_fail++;
            $display("FAIL rnd_drain got words outstanding want all delivered");
        end
        src_p = 100;
        arb_rdy = 1'b1;
        $display("test_random done: %0d words out", n_out);
    endtask

    initial begin
        srst    = 1'b1;
        req_vld = '0;
        req_lst = '0;
        req_bus = '0;
        arb_rdy = 1'b1;
        test_reset();
        test_round_robin();
        test_burst_split();
        test_stall();
        test_ptr_resume();
        test_reset_mid();
        test_passthru();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
